// File: rtl/wishbus_copy_initiator.sv
// Block-copy bus initiator: moves len words from src to dst as read/write access pairs over one
// wishbus user slot, aborting the copy when any single wait state lasts TIMEOUT cycles.
module wishbus_copy_initiator #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned LEN_W   = 10,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [LEN_W-1:0]  words_o,
  output logic              bus_rst_i,
  output logic              bus_sel_i,
  output logic              bus_stb_i,
  output logic              bus_we_i,
  output logic [ADDR_W-1:0] bus_addr_i,
  output logic [DATA_W-1:0] bus_dat_o,
  input  logic              bus_ack_o,
  input  logic              bus_cyc_o,
  input  logic [DATA_W-1:0] bus_dat_i
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StReq, StStb, StWaitHi, StWaitLo, StRel} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_words;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] r_dat;
  logic [TMR_W-1:0]  r_tmr;
  logic              r_wr;
  logic              r_sel;
  logic              r_stb;
  logic              r_we;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              w_stall;
  logic              w_abort;

  // A wait state is stalled while the event it is waiting for has not arrived.
  always_comb begin
    w_stall = 1'b0;
    case (r_state)
      StReq:    w_stall = !bus_ack_o;
      StWaitHi: w_stall = !bus_cyc_o;
      StWaitLo: w_stall = bus_cyc_o;
      default:  w_stall = 1'b0;
    endcase
    w_abort = w_stall && (r_tmr == TMR_LAST);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= StIdle;
      r_src   <= '0;
      r_dst   <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_words <= '0;
      r_word  <= '0;
      r_dat   <= '0;
      r_tmr   <= '0;
      r_wr    <= 1'b0;
      r_sel   <= 1'b1;
      r_stb   <= 1'b0;
      r_we    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_stb  <= 1'b0;
      r_tmr  <= '0;
      if (w_abort) begin
        r_state <= StIdle;
        r_sel   <= 1'b1;
        r_we    <= 1'b1;
        r_addr  <= '0;
        r_dat   <= '0;
        r_err   <= 1'b1;
        r_done  <= 1'b1;
        r_busy  <= 1'b0;
      end else if (w_stall) begin
        r_tmr <= r_tmr + 1'b1;
      end else begin
        case (r_state)
          StIdle: begin
            // The done cycle still reads as idle, so a start landing on it is dropped here.
            if (start_i && !r_done) begin
              r_src   <= src_addr_i;
              r_dst   <= dst_addr_i;
              r_len   <= len_i;
              r_words <= '0;
              r_err   <= 1'b0;
              r_wr    <= 1'b0;
              if (len_i == '0) begin
                r_done <= 1'b1;
              end else begin
                r_busy  <= 1'b1;
                r_sel   <= 1'b0;
                r_state <= StReq;
              end
            end
          end
          StReq: begin
            r_state <= StStb;
            r_stb   <= 1'b1;
            r_addr  <= r_wr ? r_dst : r_src;
            r_we    <= !r_wr;
            r_dat   <= r_wr ? r_word : '0;
          end
          StStb:    r_state <= StWaitHi;
          StWaitHi: r_state <= StWaitLo;
          StWaitLo: begin
            if (!r_wr) begin
              r_word <= bus_dat_i;
              r_wr   <= 1'b1;
            end else begin
              r_words <= r_words + 1'b1;
              r_src   <= r_src + 1'b1;
              r_dst   <= r_dst + 1'b1;
              r_wr    <= 1'b0;
            end
            r_sel   <= 1'b1;
            r_we    <= 1'b1;
            r_addr  <= '0;
            r_dat   <= '0;
            r_state <= StRel;
          end
          StRel: begin
            if (r_words == r_len) begin
              r_state <= StIdle;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_sel   <= 1'b0;
              r_state <= StReq;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign words_o    = r_words;
  assign bus_rst_i  = 1'b0;
  assign bus_sel_i  = r_sel;
  assign bus_stb_i  = r_stb;
  assign bus_we_i   = r_we;
  assign bus_addr_i = r_addr;
  assign bus_dat_o  = r_dat;

endmodule
